hazard_scheduler: RTL and testbench

Pipeline hazard and stall scheduler for the five-stage static-pipeline MIPS CPU. It tracks the destination register, write-enable, load and memory-access flags of instructions in ID/EX, EX/MEM and MEM/WB using its own shadow stage registers. From that state it generates per-stage enable and flush controls plus EX-stage forwarding selects. It sits beside the instruction decoder: decoder outputs (rd, RF_W_ena, DMEM_R, DMEM_ena, jump and branch decode) feed it, and the pipeline registers and EX operand muxes consume its outputs.

---
 rtl/hazard_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_hazard_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
// hazard_scheduler : RAW/load-use stall, memory freeze, branch/jump flush and
//                    EX forwarding control for the five-stage MIPS pipeline.
// Optional feature macro: HAZARD_FORWARDING_EN (EX/MEM and MEM/WB forwarding)
// Revision: 1.0 - initial release
// ============================================================================
module hazard_scheduler #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rf_w_ena,
   input  logic              id_is_load,
   input  logic              id_dmem_ena,
   input  logic              id_is_jump,
   input  logic              ex_branch_taken,
   input  logic              mem_ready,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_ex_en,
   output logic              ex_mem_en,
   output logic              mem_wb_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cycles
);

   // SE shadow (ID/EX)
   logic              se_valid;
   logic [REG_AW-1:0] se_rd;
   logic              se_wen;
   logic              se_load;
   logic              se_dmem;
   logic [REG_AW-1:0] se_rs;
   logic [REG_AW-1:0] se_rt;
   logic              se_uses_rs;
   logic              se_uses_rt;
   // SM shadow (EX/MEM)
   logic              sm_valid;
   logic [REG_AW-1:0] sm_rd;
   logic              sm_wen;
   logic              sm_load;
   logic              sm_dmem;
   // SW shadow (MEM/WB)
   logic              sw_valid;
   logic [REG_AW-1:0] sw_rd;
   logic              sw_wen;

   logic freeze;
   logic hazard;
   logic raw_stall;

   function automatic logic producer_match(
      input logic              valid,
      input logic              wen,
      input logic [REG_AW-1:0] rd,
      input logic              used,
      input logic [REG_AW-1:0] src
   );
      return valid && wen && (rd != '0) && used && (rd == src);
   endfunction

   assign freeze = sm_valid && sm_dmem && !mem_ready;

`ifdef HAZARD_FORWARDING_EN
   // Only a load in EX cannot be forwarded in time for the ID consumer.
   assign hazard = se_load &&
                   (producer_match(se_valid, se_wen, se_rd, id_uses_rs, id_rs) ||
                    producer_match(se_valid, se_wen, se_rd, id_uses_rt, id_rt));

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (se_valid) begin
         if (producer_match(sm_valid, sm_wen, sm_rd, se_uses_rs, se_rs) && !sm_load)
            fwd_a = 2'b01;
         else if (producer_match(sw_valid, sw_wen, sw_rd, se_uses_rs, se_rs))
            fwd_a = 2'b10;
         if (producer_match(sm_valid, sm_wen, sm_rd, se_uses_rt, se_rt) && !sm_load)
            fwd_b = 2'b01;
         else if (producer_match(sw_valid, sw_wen, sw_rd, se_uses_rt, se_rt))
            fwd_b = 2'b10;
      end
   end
`else
   assign hazard = producer_match(se_valid, se_wen, se_rd, id_uses_rs, id_rs) ||
                   producer_match(se_valid, se_wen, se_rd, id_uses_rt, id_rt) ||
                   producer_match(sm_valid, sm_wen, sm_rd, id_uses_rs, id_rs) ||
                   producer_match(sm_valid, sm_wen, sm_rd, id_uses_rt, id_rt);

   assign fwd_a = 2'b00;
   assign fwd_b = 2'b00;

   // Shadow fields that only the forwarding network consumes.
   logic unused_shadow;
   assign unused_shadow = ^{sm_load, se_rs, se_rt, se_uses_rs, se_uses_rt,
                            sw_valid, sw_rd, sw_wen};
`endif

   assign raw_stall = id_valid && hazard;

   always_comb begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (freeze) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else if (ex_branch_taken) begin
         // The ID instruction is wrong-path, so any RAW stall on it is moot.
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (raw_stall) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end else if (id_valid && id_is_jump) begin
         if_id_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         se_valid   <= 1'b0;
         se_rd      <= '0;
         se_wen     <= 1'b0;
         se_load    <= 1'b0;
         se_dmem    <= 1'b0;
         se_rs      <= '0;
         se_rt      <= '0;
         se_uses_rs <= 1'b0;
         se_uses_rt <= 1'b0;
         sm_valid   <= 1'b0;
         sm_rd      <= '0;
         sm_wen     <= 1'b0;
         sm_load    <= 1'b0;
         sm_dmem    <= 1'b0;
         sw_valid   <= 1'b0;
         sw_rd      <= '0;
         sw_wen     <= 1'b0;
      end else begin
         if (id_ex_en) begin
            se_valid   <= id_valid && !id_ex_flush;
            se_rd      <= id_rd;
            se_wen     <= id_rf_w_ena;
            se_load    <= id_is_load;
            se_dmem    <= id_dmem_ena;
            se_rs      <= id_rs;
            se_rt      <= id_rt;
            se_uses_rs <= id_uses_rs;
            se_uses_rt <= id_uses_rt;
         end
         if (ex_mem_en) begin
            sm_valid <= se_valid;
            sm_rd    <= se_rd;
            sm_wen   <= se_wen;
            sm_load  <= se_load;
            sm_dmem  <= se_dmem;
         end
         if (mem_wb_en) begin
            sw_valid <= sm_valid;
            sw_rd    <= sm_rd;
            sw_wen   <= sm_wen;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (!pc_en && (stall_cycles != '1))
         stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// tb_hazard_scheduler : directed self-checking bench for hazard_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_scheduler;

`ifdef HAZARD_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
   localparam logic [6:0] CTL_RUN = 7'b1111100;
   localparam logic [6:0] CTL_RAW = 7'b0011101;
   localparam logic [6:0] CTL_BR  = 7'b1111111;
   localparam logic [6:0] CTL_JMP = 7'b1111110;
   localparam logic [6:0] CTL_FRZ = 7'b0000000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt, id_rf_w_ena, id_is_load, id_dmem_ena, id_is_jump;
   logic        ex_branch_taken, mem_ready;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cycles;
   logic [6:0]  ctl;
   logic [6:0]  exp_ctl;

   int errors = 0;
   int checks = 0;
   int s0;
   int delta;

   assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

   always #5 clk = ~clk;

   hazard_scheduler #(.REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
      .id_rf_w_ena(id_rf_w_ena), .id_is_load(id_is_load), .id_dmem_ena(id_dmem_ena),
      .id_is_jump(id_is_jump), .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_none();
      id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_rd = 0; id_rf_w_ena = 0; id_is_load = 0; id_dmem_ena = 0; id_is_jump = 0;
   endtask

   task automatic id_alu(input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] rd);
      id_none();
      id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rs = 1; id_uses_rt = urt;
      id_rd = rd; id_rf_w_ena = 1;
   endtask

   task automatic id_lw(input logic [4:0] rs, input logic [4:0] rd);
      id_none();
      id_valid = 1; id_rs = rs; id_rt = rd; id_uses_rs = 1; id_rd = rd;
      id_rf_w_ena = 1; id_is_load = 1; id_dmem_ena = 1;
   endtask

   task automatic drain();
      id_none();
      ex_branch_taken = 0;
      mem_ready = 1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst_n = 1; mem_ready = 1; ex_branch_taken = 0;
      id_none();
      #1 rst_n = 0;
      #2;
      checks++;
      if (ctl !== CTL_RUN) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RUN); end
      checks++;
      if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL reset_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
      checks++;
      if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
      #1 rst_n = 1;
      tick();
   endtask

   // add $3,$1,$2 ; sub $4,$3,$5
   task automatic test_fwd_exmem();
      drain();
      s0 = int'(stall_cycles);
      id_alu(5'd1, 5'd2, 1'b1, 5'd3); #1;
      checks++;
      if (ctl !== CTL_RUN) begin errors++; $display("FAIL exmem_c1 got=%b exp=%b", ctl, CTL_RUN); end
      tick();
      id_alu(5'd3, 5'd5, 1'b1, 5'd4); #1;
      exp_ctl = FWD ? CTL_RUN : CTL_RAW;
      checks++;
      if (ctl !== exp_ctl) begin errors++; $display("FAIL exmem_c2 got=%b exp=%b", ctl, exp_ctl); end
      tick();
      if (FWD) id_none();
      #1;
      exp_ctl = FWD ? CTL_RUN : CTL_RAW;
      checks++;
      if (ctl !== exp_ctl) begin errors++; $display("FAIL exmem_c3 got=%b exp=%b", ctl, exp_ctl); end
      checks++;
      if ({fwd_a, fwd_b} !== (FWD ? 4'b0100 : 4'b0000)) begin
         errors++; $display("FAIL exmem_fwd got=%b exp=%b", {fwd_a, fwd_b}, (FWD ? 4'b0100 : 4'b0000));
      end
      tick();
      if (FWD) id_none();
      #1;
      checks++;
      if (ctl !== CTL_RUN) begin errors++; $display("FAIL exmem_c4 got=%b exp=%b", ctl, CTL_RUN); end
      tick();
      id_none(); #1;
      checks++;
      if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL exmem_fwd_end got=%b exp=0000", {fwd_a, fwd_b}); end
      delta = int'(stall_cycles) - s0;
      checks++;
      if (delta !== (FWD ? 0 : 2)) begin errors++; $display("FAIL exmem_cnt got=%0d exp=%0d", delta, (FWD ? 0 : 2)); end
   endtask

   // lw $3,0($1) ; add $4,$3,$3
   task automatic test_load_use();
      drain();
      s0 = int'(stall_cycles);
      id_lw(5'd1, 5'd3); #1;
      checks++;
      if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_c1 got=%b exp=%b", ctl, CTL_RUN); end
      tick();
      id_alu(5'd3, 5'd3, 1'b1, 5'd4); #1;
      checks++;
      if (ctl !== CTL_RAW) begin errors++; $display("FAIL lu_c2 got=%b exp=%b", ctl, CTL_RAW); end
      tick();
      exp_ctl = FWD ? CTL_RUN : CTL_RAW;
      checks++;
      if (ctl !== exp_ctl) begin errors++; $display("FAIL lu_c3 got=%b exp=%b", ctl, exp_ctl); end
      tick();
      if (FWD) id_none();
      #1;
      checks++;
      if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_c4 got=%b exp=%b", ctl, CTL_RUN); end
      checks++;
      if ({fwd_a, fwd_b} !== (FWD ? 4'b1010 : 4'b0000)) begin
         errors++; $display("FAIL lu_fwd got=%b exp=%b", {fwd_a, fwd_b}, (FWD ? 4'b1010 : 4'b0000));
      end
      delta = int'(stall_cycles) - s0;
      checks++;
      if (delta !== (FWD ? 1 : 2)) begin errors++; $display("FAIL lu_cnt got=%0d exp=%0d", delta, (FWD ? 1 : 2)); end
      tick();
      id_none();
   endtask

   // addi $0,$0,5 ; add $6,$0,$0
   task automatic test_zero_reg();
      drain();
      s0 = int'(stall_cycles);
      id_alu(5'd0, 5'd0, 1'b0, 5'd0); #1;
      tick();
      id_alu(5'd0, 5'd0, 1'b1, 5'd6); #1;
      checks++;
      if (ctl !== CTL_RUN) begin errors++; $display("FAIL zero_c2 got=%b exp=%b", ctl, CTL_RUN); end
      tick();
      id_none(); #1;
      checks++;
      if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL zero_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
      delta = int'(stall_cycles) - s0;
      checks++;
      if (delta !== 0) begin errors++; $display("FAIL zero_cnt got=%0d exp=0", delta); end
   endtask

   task automatic test_branch_vs_stall();
      drain();
      id_lw(5'd1, 5'd3); #1;
      tick();
      id_alu(5'd3, 5'd3, 1'b1, 5'd4);
      ex_branch_taken = 1; #1;
      checks++;
      if (ctl !== CTL_BR) begin errors++; $display("FAIL br_ctl got=%b exp=%b", ctl, CTL_BR); end
      tick();
      ex_branch_taken = 0;
      id_alu(5'd3, 5'd2, 1'b1, 5'd7); #1;
      exp_ctl = FWD ? CTL_RUN : CTL_RAW;
      checks++;
      if (ctl !== exp_ctl) begin errors++; $display("FAIL br_after got=%b exp=%b", ctl, exp_ctl); end
      tick();
      id_none();
   endtask

   task automatic test_freeze();
      drain();
      id_lw(5'd1, 5'd3); #1;
      tick();
      id_none(); #1;
      tick();
      s0 = int'(stall_cycles);
      id_none();
      id_valid = 1; id_rd = 5'd31; id_rf_w_ena = 1; id_is_jump = 1;
      mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         ex_branch_taken = (i == 1);
         #1;
         checks++;
         if (ctl !== CTL_FRZ) begin errors++; $display("FAIL frz_c%0d got=%b exp=%b", i, ctl, CTL_FRZ); end
         tick();
      end
      ex_branch_taken = 0;
      mem_ready = 1; #1;
      checks++;
      if (ctl !== CTL_JMP) begin errors++; $display("FAIL frz_release got=%b exp=%b", ctl, CTL_JMP); end
      delta = int'(stall_cycles) - s0;
      checks++;
      if (delta !== 3) begin errors++; $display("FAIL frz_cnt got=%0d exp=3", delta); end
      tick();
      id_none();
   endtask

   task automatic test_async_reset();
      drain();
      id_lw(5'd1, 5'd3); #1;
      tick();
      id_alu(5'd3, 5'd3, 1'b1, 5'd4); #1;
      checks++;
      if (ctl !== CTL_RAW) begin errors++; $display("FAIL ar_pre got=%b exp=%b", ctl, CTL_RAW); end
      #2 rst_n = 0;
      #1;
      checks++;
      if (ctl !== CTL_RUN) begin errors++; $display("FAIL ar_ctl got=%b exp=%b", ctl, CTL_RUN); end
      checks++;
      if (stall_cycles !== 16'd0) begin errors++; $display("FAIL ar_cnt got=%0d exp=0", stall_cycles); end
      #1 rst_n = 1;
      tick();
      id_none(); #1;
      checks++;
      if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL ar_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
   endtask

   initial begin
      test_reset();
      test_fwd_exmem();
      test_load_use();
      test_zero_reg();
      test_branch_vs_stall();
      test_freeze();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
